serial_adder_nbit: RTL and testbench
====================================

# serial_adder_nbit

Parametrised bit-serial (digit-serial) adder/subtractor built from a chain of full-adder cells. It processes `DIGIT` bits per clock, holding the carry in a register between digits. This lets wide operands share one small `DIGIT`-bit adder slice over `WIDTH/DIGIT` cycles. It sits in the adder library as the sequential successor to the single-bit full adder and is wrapped by valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `DIGIT`, 1: bits processed per cycle; must divide `WIDTH` exactly (checked at elaboration).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and mode are presented.
- `in_ready`  output  1  block is idle and can accept operands.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in, used in add mode only.
- `mode`  input  1  0 = add (a + b + cin); 1 = subtract (a − b; `cin` ignored).
- `out_valid`  output  1  result is held on the outputs.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  WIDTH  result.
- `cout`  output  1  add: carry out. Subtract: 1 = no borrow (a ≥ b unsigned).
- `overflow`  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. `STEPS = WIDTH/DIGIT`.
- IDLE
  - `in_ready` = 1.
  - When `in_valid` is high: latch `a` into the A shift register and `b` (bitwise inverted if `mode` = 1) into the B shift register.
  - Seed the carry register with `cin` in add mode, or 1 in subtract mode.
  - Clear the step counter and go to RUN.
- RUN
  - Each cycle, add the low `DIGIT` bits of A and B plus the carry register through the digit slice.
  - Shift A and B right by `DIGIT`.
  - Shift the slice result into the MSB end of the sum register.
  - Update the carry register.
  - On the final step, also capture the carry into the MSB as `c_msb`.
  - After `STEPS` cycles, go to DONE.
- DONE
  - `out_valid` = 1; `sum`, `cout` and `overflow` are stable.
  - `overflow` = `c_msb` XOR `cout`.
  - When `out_ready` is high, go to IDLE.
- `in_ready` is high only in IDLE, so no new operands are accepted in RUN or DONE, including the cycle the result is consumed.
- Inputs `a`, `b`, `cin` and `mode` are sampled only at acceptance; later changes have no effect.
- Width rule: all arithmetic is modulo 2^WIDTH; `cout` is the carry out of bit WIDTH−1.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; all registers clear.
  - `in_ready` = 1; `out_valid` = 0; `sum` = 0; `cout` = 0; `overflow` = 0.
  - An operation in progress is discarded and no result is emitted.
- Latency: operands accepted at edge k give `out_valid` = 1 after edge k + `STEPS` (8 cycles for 8/1, 2 cycles for 8/4).
- Throughput: one result per `STEPS` + 2 cycles at best (accept, `STEPS` RUN cycles, consume).
- Backpressure: while `out_ready` = 0 in DONE, the outputs hold indefinitely with no change.
- `out_valid` and `in_ready` are never high in the same cycle.
- `DIGIT` = `WIDTH` degenerates to a one-cycle RUN; this is a legal configuration.

## Structure
- Package `serial_adder_pkg`:
  - state enum `{IDLE, RUN, DONE}`;
  - mode constants `MODE_ADD` = 0 and `MODE_SUB` = 1.
- Sub-module `fa_digit`: a combinational `DIGIT`-bit ripple of full-adder cells.
  - Ports: `x`, `y`, `ci` → `s`, `co`, `c_last_in` (the carry into its top bit, used for overflow).
- Top level holds the FSM, step counter (width `$clog2(STEPS+1)`), shift registers and carry register.

## Test plan
- 8/1, add, a=0xFF, b=0x01, cin=0 → after 8 cycles `sum`=0x00, `cout`=1, `overflow`=0.
- 8/1, add, a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `overflow`=1. Then sub, a=0x05, b=0x07 → `sum`=0xFE, `cout`=0, `overflow`=0.
- 8/4, add, a=0x3C, b=0x4B, cin=1 → `out_valid` exactly 2 cycles after acceptance; `sum`=0x88, `cout`=0, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0 throughout; result consumed on the first `out_ready`=1.
- Reset mid-RUN: deassert `rst_n` at step 3 → all outputs 0 and `in_ready`=1 immediately; a fresh operation (0x10+0x20) afterwards gives 0x30.
- WIDTH=4, DIGIT=1 and DIGIT=2: exhaustive a, b, cin, mode against a reference model; check sum, cout and overflow.

Source files
------------

// File: rtl/serial_adder_nbit_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_nbit_if.sv
// Operand/result handshake bundle for serial_adder_nbit.
// The master side presents operands and consumes results; the slave is the adder.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/serial_adder_nbit_fa_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells. Also exposes the carry
// into its top bit so the parent can form signed overflow on the final digit.
module fa_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_last_in
);

  logic [DIGIT:0] c;

  // Ripple the carry through each full-adder cell from LSB to MSB.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co        = c[DIGIT];
  assign c_last_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT
// cycles, with the carry held in a register between digits.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready high; waiting for operands
//   RUN   | one digit per cycle through the slice, STEPS cycles
//   DONE  | out_valid high; result held until out_ready
module serial_adder_nbit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_nbit_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_msb_q, c_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready;
  logic               out_valid;
  logic [DIGIT-1:0]   dg_s;
  logic               dg_co;
  logic               dg_c_last;

  fa_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x         (a_q[DIGIT-1:0]),
    .y         (b_q[DIGIT-1:0]),
    .ci        (carry_q),
    .s         (dg_s),
    .co        (dg_co),
    .c_last_in (dg_c_last)
  );

  // Next-state and datapath update; subtraction is a + ~b + 1 via the carry seed.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    c_msb_d   = c_msb_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
          carry_d = (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = WIDTH'({dg_s, sum_q} >> DIGIT);
        carry_d = dg_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          c_msb_d = dg_c_last;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
  assign bus.overflow  = c_msb_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: four configurations (8/1, 8/4, 4/1, 4/2) share
// one clock and reset; results are compared against an arithmetic model.
module tb_serial_adder_nbit;

  logic clk;
  logic rst_n;

  logic [3:0]      in_valid_s;
  logic [3:0]      cin_s;
  logic [3:0]      mode_s;
  logic [3:0]      out_ready_s;
  logic [3:0][7:0] a_s;
  logic [3:0][7:0] b_s;

  wire [3:0]       in_ready_o;
  wire [3:0]       out_valid_o;
  wire [3:0]       cout_o;
  wire [3:0]       ovf_o;
  wire [3:0][7:0]  sum_o;

  int n_checks;
  int n_errors;

  serial_adder_nbit_if #(.WIDTH(8)) if0 ();
  serial_adder_nbit_if #(.WIDTH(8)) if1 ();
  serial_adder_nbit_if #(.WIDTH(4)) if2 ();
  serial_adder_nbit_if #(.WIDTH(4)) if3 ();

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder_nbit #(.WIDTH(4), .DIGIT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder_nbit #(.WIDTH(4), .DIGIT(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.in_valid = in_valid_s[0];
  assign if0.a        = a_s[0];
  assign if0.b        = b_s[0];
  assign if0.cin      = cin_s[0];
  assign if0.mode     = mode_s[0];
  assign if0.out_ready = out_ready_s[0];
  assign in_ready_o[0]  = if0.in_ready;
  assign out_valid_o[0] = if0.out_valid;
  assign sum_o[0]       = if0.sum;
  assign cout_o[0]      = if0.cout;
  assign ovf_o[0]       = if0.overflow;

  assign if1.in_valid = in_valid_s[1];
  assign if1.a        = a_s[1];
  assign if1.b        = b_s[1];
  assign if1.cin      = cin_s[1];
  assign if1.mode     = mode_s[1];
  assign if1.out_ready = out_ready_s[1];
  assign in_ready_o[1]  = if1.in_ready;
  assign out_valid_o[1] = if1.out_valid;
  assign sum_o[1]       = if1.sum;
  assign cout_o[1]      = if1.cout;
  assign ovf_o[1]       = if1.overflow;

  assign if2.in_valid = in_valid_s[2];
  assign if2.a        = a_s[2][3:0];
  assign if2.b        = b_s[2][3:0];
  assign if2.cin      = cin_s[2];
  assign if2.mode     = mode_s[2];
  assign if2.out_ready = out_ready_s[2];
  assign in_ready_o[2]  = if2.in_ready;
  assign out_valid_o[2] = if2.out_valid;
  assign sum_o[2]       = {4'h0, if2.sum};
  assign cout_o[2]      = if2.cout;
  assign ovf_o[2]       = if2.overflow;

  assign if3.in_valid = in_valid_s[3];
  assign if3.a        = a_s[3][3:0];
  assign if3.b        = b_s[3][3:0];
  assign if3.cin      = cin_s[3];
  assign if3.mode     = mode_s[3];
  assign if3.out_ready = out_ready_s[3];
  assign in_ready_o[3]  = if3.in_ready;
  assign out_valid_o[3] = if3.out_valid;
  assign sum_o[3]       = {4'h0, if3.sum};
  assign cout_o[3]      = if3.cout;
  assign ovf_o[3]       = if3.overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular and signed-range arithmetic on the operand values.
  function automatic void ref_calc(input int w, input int a, input int b, input int cin,
                                   input int mode, output int s, output int c, output int ov);
    int m;
    int sa;
    int sb;
    int full;
    int sres;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (mode == 0) begin
      full = a + b + cin;
      c    = (full >= m) ? 1 : 0;
      sres = sa + sb + cin;
    end else begin
      full = a - b;
      c    = (a >= b) ? 1 : 0;
      sres = sa - sb;
    end
    s  = ((full % m) + m) % m;
    ov = (sres < -(m / 2) || sres > (m / 2 - 1)) ? 1 : 0;
  endfunction

  function automatic int steps_of(input int idx);
    case (idx)
      0: return 8;
      1: return 2;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  // One full transaction on DUT idx: accept, wait for result, hold, consume.
  task automatic do_op(input int idx, input int a, input int b, input int cin,
                       input int mode, input int hold, input string tag);
    int w;
    int lat;
    int es;
    int ec;
    int eo;
    logic busy_seen;
    w = (idx < 2) ? 8 : 4;
    ref_calc(w, a, b, cin, mode, es, ec, eo);
    @(negedge clk);
    check_eq({tag, ":idle_ready"}, in_ready_o[idx], 1);
    in_valid_s[idx] = 1'b1;
    a_s[idx]        = 8'(a);
    b_s[idx]        = 8'(b);
    cin_s[idx]      = 1'(cin);
    mode_s[idx]     = 1'(mode);
    @(posedge clk);
    #1;
    in_valid_s[idx] = 1'b0;
    a_s[idx]        = 8'($urandom);
    b_s[idx]        = 8'($urandom);
    cin_s[idx]      = 1'($urandom);
    mode_s[idx]     = 1'($urandom);
    lat       = 0;
    busy_seen = 1'b0;
    while (!out_valid_o[idx] && lat < 64) begin
      busy_seen = busy_seen | in_ready_o[idx];
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, ":latency"}, lat, steps_of(idx));
    check_eq({tag, ":busy_ready"}, busy_seen, 0);
    check_eq({tag, ":sum"}, sum_o[idx], es);
    check_eq({tag, ":cout"}, cout_o[idx], ec);
    check_eq({tag, ":ovf"}, ovf_o[idx], eo);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ":hold_hs"}, {out_valid_o[idx], in_ready_o[idx]}, 2'b10);
      check_eq({tag, ":hold_res"}, {sum_o[idx], cout_o[idx], ovf_o[idx]},
               {8'(es), 1'(ec), 1'(eo)});
    end
    out_ready_s[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[idx] = 1'b0;
    check_eq({tag, ":consumed"}, {out_valid_o[idx], in_ready_o[idx]}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    in_valid_s  = '0;
    cin_s       = '0;
    mode_s      = '0;
    out_ready_s = '0;
    a_s         = '0;
    b_s         = '0;

    #12;
    for (int i = 0; i < 4; i++) begin
      check_eq("reset_hs", {in_ready_o[i], out_valid_o[i]}, 2'b10);
      check_eq("reset_res", {sum_o[i], cout_o[i], ovf_o[i]}, 10'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 'hFF, 'h01, 0, 0, 0, "add_ff_01");
    do_op(0, 'h7F, 'h01, 0, 0, 0, "add_7f_01");
    do_op(0, 'h05, 'h07, 0, 1, 0, "sub_05_07");
    do_op(1, 'h3C, 'h4B, 1, 0, 0, "d4_add_3c_4b");
    do_op(0, 'hA5, 'h5A, 1, 0, 5, "backpressure");
    do_op(1, 'h80, 'h01, 1, 1, 0, "d4_sub_cin_ignored");

    // Abort an operation three steps in; nothing may come out of it.
    @(negedge clk);
    in_valid_s[0] = 1'b1;
    a_s[0]        = 8'hFF;
    b_s[0]        = 8'h00;
    cin_s[0]      = 1'b0;
    mode_s[0]     = 1'b0;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_hs", {in_ready_o[0], out_valid_o[0]}, 2'b10);
    check_eq("rst_mid_res", {sum_o[0], cout_o[0], ovf_o[0]}, 10'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid_o[0]) cnt++;
    end
    check_eq("rst_no_result", cnt, 0);
    do_op(0, 'h10, 'h20, 0, 0, 0, "rst_fresh");

    for (int idx = 2; idx < 4; idx++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int md = 0; md < 2; md++) begin
            for (int ci = 0; ci < 2; ci++) begin
              do_op(idx, a, b, ci, md, 0, "exh4");
            end
          end
        end
      end
    end

    for (int n = 0; n < 150; n++) begin
      do_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), "rnd_d1");
      do_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), "rnd_d4");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
